switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter NUM_SW, default 4, the number of switch inputs debounced as one vector.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000, the number of consecutive stable clocks required to accept a new vector (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sw_raw, input, NUM_SW, asynchronous bouncing DIP-switch levels.
REQ-006 SHALL have port s, output, NUM_SW, debounced switch vector that feeds the LED-control stage.
REQ-007 SHALL have port busy, output, 1, high while a candidate vector is being qualified.

Function
REQ-008 SHALL pass each sw_raw bit through a two-flop synchronizer; the output of the second flop is called sw_sync.
REQ-009 SHALL debounce the vector as a whole with a 2-state FSM (IDLE, WAIT), a candidate register cand of NUM_SW bits, and a counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-010 In IDLE with sw_sync==s: hold all state, busy=0.
REQ-011 In IDLE with sw_sync!=s: cand<=sw_sync, cnt<=0, go to WAIT.
REQ-012 In WAIT with sw_sync==cand and cnt==DEBOUNCE_CYCLES-1: s<=cand, go to IDLE.
REQ-013 In WAIT with sw_sync==cand and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
REQ-014 In WAIT with sw_sync!=cand and sw_sync==s (bounce back to the accepted value): go to IDLE, s unchanged, cnt<=0.
REQ-015 In WAIT with sw_sync!=cand and sw_sync!=s (new candidate): cand<=sw_sync, cnt<=0, stay in WAIT.
REQ-016 busy SHALL equal 1 exactly when the state is WAIT (registered, no combinational path from sw_raw).
REQ-017 Latency: if sw_raw changes before clock edge k and then stays stable, s SHALL update at edge k+DEBOUNCE_CYCLES+2, and at no earlier edge.
REQ-018 Multiple bits changing at different edges SHALL restart qualification per REQ-015; s SHALL never show a vector that was not stable for DEBOUNCE_CYCLES consecutive clocks.
REQ-019 cnt SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 by construction of REQ-012.
REQ-020 s SHALL change only on clk rising edges and only by a full-vector load from cand.

Reset
REQ-021 While reset=1, the synchronizer flops, cand, cnt and s SHALL be 0, the state SHALL be IDLE, and busy SHALL be 0, all asynchronously.
REQ-022 Assertion of reset mid-WAIT SHALL discard the candidate; after release, a held non-zero sw_raw SHALL be re-qualified from scratch per REQ-017.

Configuration
REQ-023 Macro SWDB_CHANGE_STROBE_EN, when defined, SHALL add an output port s_changed (1 bit), which pulses high for exactly one clock in the cycle after s is loaded with a value different from its previous value; it is 0 under reset.
REQ-024 Without SWDB_CHANGE_STROBE_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package swdb_pkg SHALL hold the FSM state enum (IDLE, WAIT) and the constant SWDB_DEFAULT_CYCLES=20000.
REQ-026 Synchronization SHALL be a sub-module sync_2ff (parameter WIDTH, ports clk, reset, d, q), instantiated once with WIDTH=NUM_SW.

Verification (DEBOUNCE_CYCLES=4, NUM_SW=4)
REQ-027 Reset with sw_raw=4'b1111 -> s=0 and busy=0 during reset; after release, s=4'b1111 at edge 6 after release, with busy high from edge 2 through edge 5.
REQ-028 sw_raw 0->4'b0011 held stable before edge k -> s=4'b0011 at edge k+6, and s=0 at edges k..k+5.
REQ-029 sw_raw toggles 0->4'b0001->0 with each value held 2 clocks -> s stays 0 throughout, and busy falls after the return to 0.
REQ-030 sw_raw 0->4'b0001, then 4'b0101 two clocks later, then held -> s=4'b0101 at 6 edges after the second change, and s never equals 4'b0001.
REQ-031 reset asserted asynchronously mid-WAIT (between clock edges) -> s, busy and cnt are 0 immediately; after release, re-qualification proceeds per REQ-027.
REQ-032 With SWDB_CHANGE_STROBE_EN, s goes 0->4'b1100 -> s_changed is high for exactly one cycle, at the edge after s updates; a new candidate identical to s produces no pulse.

Source files
------------

// File: rtl/swdb_pkg.sv
// Shared definitions for the switch debouncer: FSM state type and the
// default qualification length.
package swdb_pkg;

    localparam int SWDB_DEFAULT_CYCLES = 20000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } swdb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a vector of asynchronous levels.
// Each bit is synchronized independently; the vector as a whole is not
// guaranteed coherent, which is why the debouncer qualifies the full vector.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the raw level through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_debounce.sv
// Whole-vector switch debouncer.
// A new switch vector is accepted only after the synchronized input has
// matched it for DEBOUNCE_CYCLES consecutive clocks; any change restarts
// qualification and a return to the accepted value abandons it.
//
// Optional build macro: SWDB_CHANGE_STROBE_EN adds output s_changed, a
// one-clock pulse in the cycle after s takes a new value.
//
// state | meaning
// IDLE  | sw_sync matches s, nothing to qualify
// WAIT  | counting stable clocks of candidate vector cand
module switch_debounce
    import swdb_pkg::*;
#(
    parameter int NUM_SW          = 4,
    parameter int DEBOUNCE_CYCLES = SWDB_DEFAULT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] s,
    output logic              busy
`ifdef SWDB_CHANGE_STROBE_EN
    ,
    output logic              s_changed
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] sw_sync;

    swdb_state_e       state_q, state_d;
    logic [NUM_SW-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_SW-1:0] s_q, s_d;

    sync_2ff #(
        .WIDTH (NUM_SW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_sync)
    );

    // Next-state logic: qualify a candidate vector, restart on any change.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (sw_sync != s_q) begin
                    cand_d  = sw_sync;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sw_sync == cand_q) begin
                    // cnt stops at CNT_LAST because that value always loads s
                    if (cnt_q == CNT_LAST) begin
                        s_d     = cand_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sw_sync == s_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cand_d = sw_sync;
                    cnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, candidate, counter and accepted-vector registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

    assign s    = s_q;
    assign busy = (state_q == WAIT);

`ifdef SWDB_CHANGE_STROBE_EN
    logic [NUM_SW-1:0] s_prev_q, s_prev_d;
    logic              s_changed_q, s_changed_d;

    // Compare s with its value one clock earlier to flag a fresh load.
    always_comb begin
        s_prev_d    = s_q;
        s_changed_d = (s_q != s_prev_q);
    end

    // Change-strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_prev_q    <= '0;
            s_changed_q <= 1'b0;
        end else begin
            s_prev_q    <= s_prev_d;
            s_changed_q <= s_changed_d;
        end
    end

    assign s_changed = s_changed_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (NUM_SW=4, DEBOUNCE_CYCLES=4).
module tb_switch_debounce;

    localparam int NUM_SW = 4;
    localparam int DC     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] s;
    logic              busy;
`ifdef SWDB_CHANGE_STROBE_EN
    logic              s_changed;
`endif

    switch_debounce #(
        .NUM_SW          (NUM_SW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .s         (s),
`ifdef SWDB_CHANGE_STROBE_EN
        .s_changed (s_changed),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a vector is accepted once the synchronized input
    // (raw delayed by two clocks) has shown it on DC+1 consecutive edges
    // while it differs from the accepted value.
    logic [NUM_SW-1:0] raw_hist[$];
    logic [NUM_SW-1:0] m_s, run_val;
    int                run_len;
    bit                m_busy, m_chg, prev_load;

    task automatic model_reset();
        raw_hist.delete();
        m_s       = '0;
        run_val   = '0;
        run_len   = 1;
        m_busy    = 1'b0;
        m_chg     = 1'b0;
        prev_load = 1'b0;
    endtask

    task automatic model_edge(input logic [NUM_SW-1:0] raw);
        logic [NUM_SW-1:0] seen;
        bit                load;
        raw_hist.push_back(raw);
        seen = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3] : '0;
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        if (seen == run_val) run_len++;
        else begin
            run_val = seen;
            run_len = 1;
        end
        load      = (run_val != m_s) && (run_len >= DC + 1);
        m_chg     = prev_load;
        prev_load = load;
        if (load) m_s = run_val;
        m_busy = (seen != m_s);
    endtask

    // Drive raw before the next rising edge, sample on the falling edge.
    task automatic step(input logic [NUM_SW-1:0] v);
        sw_raw = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NUM_SW-1:0] v);
        @(negedge clk);
        sw_raw = v;
        #1 reset = 1'b1;
        #1;
        check("rst_async_s", s, 0);
        check("rst_async_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_held_s", s, 0);
        check("rst_held_busy", busy, 0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [NUM_SW-1:0] raw;
        logic [NUM_SW-1:0] exp_s;
        logic              exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] raw, input logic [3:0] es, input logic eb);
        vec_t v;
        v.raw      = raw;
        v.exp_s    = es;
        v.exp_busy = eb;
        tbl.push_back(v);
    endfunction

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        model_reset();

        // glitch 0 -> 1 -> 0, two clocks each: never accepted
        add(4'h1, 4'h0, 0); add(4'h1, 4'h0, 0); add(4'h0, 4'h0, 1); add(4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0); add(4'h0, 4'h0, 0); add(4'h0, 4'h0, 0); add(4'h0, 4'h0, 0);
        // 0 -> 3 held: accepted on the seventh edge
        add(4'h3, 4'h0, 0); add(4'h3, 4'h0, 0); add(4'h3, 4'h0, 1); add(4'h3, 4'h0, 1);
        add(4'h3, 4'h0, 1); add(4'h3, 4'h0, 1); add(4'h3, 4'h3, 0); add(4'h3, 4'h3, 0);
        // 3 -> 0 held
        add(4'h0, 4'h3, 0); add(4'h0, 4'h3, 0); add(4'h0, 4'h3, 1); add(4'h0, 4'h3, 1);
        add(4'h0, 4'h3, 1); add(4'h0, 4'h3, 1); add(4'h0, 4'h0, 0);
        // 0 -> 1 then 5 two clocks later: 1 is never shown
        add(4'h1, 4'h0, 0); add(4'h1, 4'h0, 0); add(4'h5, 4'h0, 1); add(4'h5, 4'h0, 1);
        add(4'h5, 4'h0, 1); add(4'h5, 4'h0, 1); add(4'h5, 4'h0, 1); add(4'h5, 4'h0, 1);
        add(4'h5, 4'h5, 0); add(4'h5, 4'h5, 0);

        repeat (2) @(negedge clk);

        // Out of reset with all switches on
        do_reset(4'hF);
        for (int e = 0; e < 8; e++) begin
            step(4'hF);
            check("rel_s", s, (e >= 6) ? 4'hF : 4'h0);
            check("rel_busy", busy, (e >= 2 && e <= 5) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a qualification
        for (int e = 0; e < 4; e++) step(4'hA);
        check("midwait_busy_pre", busy, 1);
        check("midwait_cnt_pre", dut.cnt_q, 1);
        #2 reset = 1'b1;
        #1;
        check("midwait_rst_s", s, 0);
        check("midwait_rst_busy", busy, 0);
        check("midwait_rst_cnt", dut.cnt_q, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int e = 0; e < 8; e++) begin
            step(4'hA);
            check("requal_s", s, (e >= 6) ? 4'hA : 4'h0);
            check("requal_busy", busy, (e >= 2 && e <= 5) ? 1 : 0);
        end

        // Directed vector table
        do_reset(4'h0);
        repeat (3) step(4'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].raw);
            if (s !== tbl[i].exp_s) begin
                $display("FAIL tbl_s[%0d]: got %0h expected %0h", i, s, tbl[i].exp_s);
                errors++;
            end
            checks++;
            check("tbl_busy", busy, tbl[i].exp_busy);
            if (tbl[i].exp_s == 4'h1) $display("unexpected table entry %0d", i);
            check("tbl_never_1", (s == 4'h1), 0);
        end

`ifdef SWDB_CHANGE_STROBE_EN
        // Change strobe on 0 -> C
        do_reset(4'h0);
        repeat (2) step(4'h0);
        for (int e = 0; e < 10; e++) begin
            step(4'hC);
            check("strobe", s_changed, (e == 7) ? 1 : 0);
        end
`endif

        // Randomized bouncing against the reference model
        do_reset(4'h0);
        for (int seg = 0; seg < 120; seg++) begin
            logic [NUM_SW-1:0] v;
            int                hold;
            v    = NUM_SW'($urandom_range(0, 15));
            hold = (seg % 3 == 0) ? $urandom_range(5, 9) : $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                step(v);
                check("rand_s", s, m_s);
                check("rand_busy", busy, m_busy);
`ifdef SWDB_CHANGE_STROBE_EN
                check("rand_chg", s_changed, m_chg);
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
